// File: rtl/ordinator_param.sv
// rtl/ordinator_param.sv - left-to-right token stream calculator with bitwise ops, sticky carry/borrow and error recovery
module ordinator_param #(
  parameter int WIDTH        = 8,
  parameter int MAX_OPERANDS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             err,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(MAX_OPERANDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPERANDS);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_EQL = 3'd5;

  typedef enum logic [1:0] {S_OPND, S_OPR, S_ERR} state_t;

  state_t           state, state_n;
  logic             first, first_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [2:0]       pending_op, pending_op_n;
  logic             ovf_acc, ovf_acc_n;
  logic [WIDTH-1:0] result_n;
  logic             ready_n, err_n, ovf_n, busy_n;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu;
  logic             alu_c;
  logic [2:0]       op;

  assign op = in[2:0];

  // Carry and borrow both fall out of the extra top bit of the widened sum/difference.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, in};
    diff  = {1'b0, acc} - {1'b0, in};
    alu   = acc;
    alu_c = 1'b0;
    case (pending_op)
      OP_ADD: begin alu = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu = acc & in;
      OP_OR:  alu = acc | in;
      OP_XOR: alu = acc ^ in;
      default: alu = acc;
    endcase
  end

  always_comb begin
    state_n      = state;
    first_n      = first;
    count_n      = count;
    acc_n        = acc;
    pending_op_n = pending_op;
    ovf_acc_n    = ovf_acc;
    result_n     = result;
    ready_n      = 1'b0;
    err_n        = err;
    ovf_n        = ovf;
    busy_n       = busy;
    if (in_valid) begin
      case (state)
        S_OPND: begin
          if (first) begin
            acc_n     = in;
            count_n   = CW'(1);
            ovf_acc_n = 1'b0;
          end else begin
            acc_n     = alu;
            count_n   = count + CW'(1);
            ovf_acc_n = ovf_acc | alu_c;
          end
          state_n = S_OPR;
          first_n = 1'b0;
          busy_n  = 1'b1;
        end
        S_OPR: begin
          if (op <= OP_XOR) begin
            if (count < MAX_CNT) begin
              pending_op_n = op;
              state_n      = S_OPND;
            end else begin
              state_n = S_ERR;
            end
          end else if (op == OP_EQL) begin
            result_n = acc;
            ovf_n    = ovf_acc;
            err_n    = 1'b0;
            ready_n  = 1'b1;
            state_n  = S_OPND;
            first_n  = 1'b1;
            busy_n   = 1'b0;
          end else begin
            state_n = S_ERR;
          end
        end
        S_ERR: begin
          // Operands are indistinguishable from operators here, so any low-bits-5 token ends the error.
          if (op == OP_EQL) begin
            result_n = '1;
            err_n    = 1'b1;
            ovf_n    = 1'b0;
            ready_n  = 1'b1;
            state_n  = S_OPND;
            first_n  = 1'b1;
            busy_n   = 1'b0;
          end
        end
        default: state_n = S_OPND;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_OPND;
      first      <= 1'b1;
      count      <= '0;
      acc        <= '0;
      pending_op <= OP_ADD;
      ovf_acc    <= 1'b0;
      result     <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      first      <= first_n;
      count      <= count_n;
      acc        <= acc_n;
      pending_op <= pending_op_n;
      ovf_acc    <= ovf_acc_n;
      result     <= result_n;
      ready      <= ready_n;
      err        <= err_n;
      ovf        <= ovf_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_ordinator_param.sv
// tb/tb_ordinator_param.sv - scoreboard bench for ordinator_param (MAX_OPERANDS 16 and 4 instances)
module tb_ordinator_param;

  localparam logic [7:0] ADD = 8'd0, SUB = 8'd1, AND_ = 8'd2, OR_ = 8'd3, XOR_ = 8'd4, EQL = 8'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in0 = '0, in1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] res0, res1;
  logic       rdy0, rdy1, err0, err1, ovf0, ovf1, busy0, busy1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       err;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  ordinator_param #(.WIDTH(8), .MAX_OPERANDS(16)) dut (
    .clk(clk), .reset(reset), .in(in0), .in_valid(v0),
    .result(res0), .ready(rdy0), .err(err0), .ovf(ovf0), .busy(busy0)
  );

  ordinator_param #(.WIDTH(8), .MAX_OPERANDS(4)) dut4 (
    .clk(clk), .reset(reset), .in(in1), .in_valid(v1),
    .result(res1), .ready(rdy1), .err(err1), .ovf(ovf1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tok(input int d, input logic [7:0] x);
    if (d == 0) begin in0 = x; v0 = 1'b1; end
    else        begin in1 = x; v1 = 1'b1; end
    @(posedge clk); #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic eql(input int d, input logic [7:0] r, input logic e, input logic o);
    exp_t x;
    tok(d, EQL);
    x.res = r; x.err = e; x.ovf = o; x.cyc = cyc;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && rdy0) begin
      if (q0.size() == 0) chk("d16 unexpected ready", 1, 0);
      else begin
        e = q0.pop_front();
        chk("d16 result", res0, e.res);
        chk("d16 err", err0, e.err);
        chk("d16 ovf", ovf0, e.ovf);
        chk("d16 ready latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && rdy1) begin
      if (q1.size() == 0) chk("d4 unexpected ready", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d4 result", res1, e.res);
        chk("d4 err", err1, e.err);
        chk("d4 ovf", ovf1, e.ovf);
        chk("d4 ready latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1;
    chk("reset result", res0, 0);
    chk("reset ready", rdy0, 0);
    chk("reset busy", busy0, 0);
    chk("reset err/ovf", {err0, ovf0}, 0);
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic add/sub, busy tracking
    tok(0, 8'd5);
    chk("t1 busy after first operand", busy0, 1);
    tok(0, ADD); tok(0, 8'd3); tok(0, SUB); tok(0, 8'd2);
    eql(0, 8'd6, 1'b0, 1'b0);
    chk("t1 busy after EQL", busy0, 0);

    // 2: carry, borrow, then sticky flag cleared by next expression
    tok(0, 8'd200); tok(0, ADD); tok(0, 8'd100); eql(0, 8'd44, 1'b0, 1'b1);
    tok(0, 8'd3); tok(0, SUB); tok(0, 8'd5); eql(0, 8'd254, 1'b0, 1'b1);
    tok(0, 8'd9); eql(0, 8'd9, 1'b0, 1'b0);

    // 3: bitwise ops with idle gaps
    tok(0, 8'h0F); idle(1); tok(0, AND_); idle(3); tok(0, 8'h3C); idle(2);
    tok(0, OR_); idle(1); tok(0, 8'h80); idle(3); tok(0, XOR_); idle(2);
    tok(0, 8'h01); idle(1);
    eql(0, 8'h8D, 1'b0, 1'b0);
    idle(2);

    // 4: invalid operator, recovery
    tok(0, 8'd7); tok(0, 8'd6);
    chk("t4 busy in error", busy0, 1);
    tok(0, 8'd4); tok(0, ADD);
    eql(0, 8'hFF, 1'b1, 1'b0);
    tok(0, 8'd1); tok(0, ADD); tok(0, 8'd1); eql(0, 8'd2, 1'b0, 1'b0);

    // 5: operand limit on the MAX_OPERANDS=4 instance
    for (int i = 0; i < 4; i++) begin
      tok(1, 8'd1); tok(1, ADD);
    end
    eql(1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tok(1, 8'd1); tok(1, ADD);
    end
    tok(1, 8'd1);
    eql(1, 8'd4, 1'b0, 1'b0);

    // 6: asynchronous reset mid-expression
    tok(0, 8'd5); tok(0, ADD);
    #2 reset = 1'b0;
    #1;
    chk("t6 reset result", res0, 0);
    chk("t6 reset busy", busy0, 0);
    chk("t6 reset ready/err/ovf", {rdy0, err0, ovf0}, 0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    tok(0, 8'd9); eql(0, 8'd9, 1'b0, 1'b0);

    idle(4);
    chk("d16 scoreboard drained", q0.size(), 0);
    chk("d4 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ordinator_param.md
Name: ordinator_param

Overview:
Parametrised successor to the 8-bit stream calculator. It consumes a token stream over a valid-qualified input: operand, operator, operand, ..., EQL. It evaluates strictly left to right into a WIDTH-bit accumulator and presents the result with a one-cycle ready pulse. It adds bitwise operators, an input valid qualifier, sticky carry/borrow reporting, an operand-count limit and explicit error recovery. It sits between the switch/button input logic and the display driver.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 3.
MAX_OPERANDS, 16, maximum operands per expression; must be >= 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in  input  WIDTH  token: operand value, or operator code in in[2:0] (upper bits ignored)
in_valid  input  1  token present this cycle; one token accepted per cycle, always accepted
result  output  WIDTH  registered result of last completed expression
ready  output  1  one-cycle pulse: result/err/ovf updated this cycle
err  output  1  qualifies result: last expression ended in error
ovf  output  1  qualifies result: carry or borrow occurred in last expression
busy  output  1  an expression is in progress (first operand accepted, EQL not yet seen)

Behaviour:
- Reset (reset=0, asynchronous):
  - result=0, ready=0, err=0, ovf=0, busy=0.
  - State S_OPND, first=1, count=0, acc=0, pending_op=ADD, ovf_acc=0.
- Operator codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQL, 6/7 invalid.
- in_valid=0: no state change; ready deasserts after its pulse.
- S_OPND (expect operand), on in_valid:
  - first=1: acc=in, count=1, ovf_acc=0.
  - first=0: acc=apply(pending_op, acc, in), count=count+1.
  - Go to S_OPR. first=0, busy=1.
- S_OPR (expect operator), on in_valid:
  - ADD..XOR with count<MAX_OPERANDS: pending_op=code, go S_OPND.
  - ADD..XOR with count==MAX_OPERANDS: go S_ERR.
  - EQL: next cycle result=acc, ovf=ovf_acc, err=0, ready=1. Go S_OPND, first=1, busy=0.
  - Code 6/7: go S_ERR.
- S_ERR:
  - busy=1. All tokens are discarded except a valid token with in[2:0]==EQL.
  - On that token: next cycle result={WIDTH{1}}, err=1, ovf=0, ready=1. Go S_OPND, first=1, busy=0.
  - In S_ERR, operand values whose low bits equal 5 are treated as EQL (documented limitation).
- Arithmetic:
  - ADD and SUB are computed in WIDTH+1 bits; result wraps mod 2^WIDTH.
  - ADD carry-out or SUB borrow (acc < in) sets ovf_acc. ovf_acc is sticky until the next first operand.
  - AND/OR/XOR never set ovf_acc.
- Latency: EQL accepted on edge n gives ready=1 and valid result/err/ovf in the cycle after edge n.
  - result/err/ovf hold until the next ready pulse; ready is never high on consecutive cycles.
- An expression may start on the cycle immediately after EQL; back-to-back expressions lose no tokens.
- A single operand followed by EQL returns that operand.
- Reset mid-expression discards all progress; outputs return to their reset values immediately.

Test Plan (WIDTH=8, MAX_OPERANDS=16 unless noted; each token with in_valid=1):
1. 5, ADD, 3, SUB, 2, EQL -> ready one cycle after EQL, result=6, err=0, ovf=0, busy low after EQL.
2. 200, ADD, 100, EQL -> result=44, ovf=1. Then 3, SUB, 5, EQL -> result=254, ovf=1. Then 9, EQL -> result=9, ovf=0.
3. 0x0F, AND, 0x3C, OR, 0x80, XOR, 0x01, EQL, with in_valid=0 gaps of 1-3 cycles between tokens -> result=0x8D, single ready pulse.
4. 7, code 6, then 4, ADD, EQL -> err=1 and result=0xFF on ready after EQL, nothing earlier. Then 1, ADD, 1, EQL -> result=2, err=0.
5. MAX_OPERANDS=4: 1, ADD, 1, ADD, 1, ADD, 1, ADD -> S_ERR on the 4th ADD. Then EQL -> result=0xFF, err=1. Then 1, ADD, 1, ADD, 1, ADD, 1, EQL -> result=4, err=0.
6. 5, ADD, then reset low for 1 cycle (asynchronous, mid-cycle) -> all outputs 0 immediately. Then 9, EQL -> result=9; ready never pulses for the aborted expression.
